ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch control stage directly downstream of the icache.
- Owns the PC and drives the icache lookup address.
- Registers each instruction on an icache hit and presents it to decode through a valid/ready handshake.
- Handles redirects from execute and fence.i flushes, and counts miss-stall cycles.

Parameters:
- ADDR_WIDTH, 32, PC/address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h3000_0000, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- rst_n_sync  input  1  reset; asynchronous, active-low.
- icache_addr  output  ADDR_WIDTH  lookup address; combinationally equal to the pc register.
- icache_data  input  DATA_WIDTH  instruction word for icache_addr; valid only when icache_hit=1.
- icache_hit  input  1  combinational hit for the current icache_addr.
- icache_fence_i  output  1  one-cycle icache invalidate pulse.
- redirect_valid  input  1  control-flow redirect from execute.
- redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] are ignored and forced to 00.
- fence_i_req  input  1  fence.i retired; always accompanied by redirect_valid in the same cycle.
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts the instruction.
- out_pc  output  ADDR_WIDTH  PC of out_inst.
- out_inst  output  DATA_WIDTH  fetched instruction.
- perf_miss_cycles  output  32  saturating count of cycles in FETCH with icache_hit=0.

Behaviour:
- Reset (asynchronous, any time, including mid-miss): pc=RESET_PC, state=FETCH, out_valid=0, out_pc=0, out_inst=0, icache_fence_i=0, perf_miss_cycles=0.
- States: FETCH, FLUSH.
- Output register is single-entry. Define accept = !out_valid || out_ready.
- Priority per cycle, highest first:
  1. redirect_valid=1: pc<={redirect_pc[ADDR_WIDTH-1:2],2'b00}; out_valid<=0 (squash, including a held instruction even if out_ready=1 that cycle). If fence_i_req=1, state<=FLUSH, else state<=FETCH. No capture occurs this cycle.
  2. state=FLUSH: icache_fence_i=1 (Moore output, exactly one cycle); no capture, pc held; state<=FETCH next cycle.
  3. state=FETCH, icache_hit=1, accept=1: out_inst<=icache_data; out_pc<=pc; out_valid<=1; pc<=pc+4, wrapping modulo 2^ADDR_WIDTH.
  4. state=FETCH, icache_hit=1, accept=0: hold pc and the output register.
  5. state=FETCH, icache_hit=0: hold pc, so icache_addr stays stable for the refill. If out_valid && out_ready, out_valid<=0.
- Miss stall: icache_addr changes during a miss only via redirect. The icache is required to re-fetch on the new address.
- Latency: hit to out_valid is 1 cycle. Sustained throughput is 1 instruction/cycle while hit=1 and out_ready=1.
- out_pc/out_inst are stable while out_valid=1 and out_ready=0.
- perf_miss_cycles increments when state=FETCH, redirect_valid=0 and icache_hit=0. It saturates at 32'hFFFF_FFFF and is not cleared by redirect or fence.
- FLUSH suppresses capture so a stale hit sampled in the invalidate cycle is never delivered.
- fence_i_req without redirect_valid is a protocol error and is ignored.

Test Plan:
- Reset release, icache_hit=1 constant, out_ready=1 -> out_valid rises 1 cycle after reset release; out_pc sequence 3000_0000, 3000_0004, 3000_0008; one instruction per cycle.
- icache_hit=0 for 5 cycles at pc 3000_0010, then hit -> icache_addr stable at 3000_0010 throughout; perf_miss_cycles +5; out_pc=3000_0010 delivered one cycle after the hit.
- out_ready=0 for 3 cycles while out_valid=1 -> out_pc/out_inst unchanged, pc not advanced; transfer completes on the first out_ready=1 cycle.
- redirect_valid=1, redirect_pc=0x8000_0102 while an instruction is held -> next cycle out_valid=0 and icache_addr=0x8000_0100; first delivered out_pc=0x8000_0100.
- fence_i_req+redirect_valid to 0x3000_0040 -> icache_fence_i high exactly one cycle (cycle after request); no out_valid during that cycle; fetch resumes at 0x3000_0040.
- Assert rst_n_sync low mid-miss, asynchronous to clock -> outputs clear immediately; after release icache_addr=RESET_PC and perf_miss_cycles=0.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: icache lookup side, execute redirect side and decode output side.
// out_valid/out_ready: a transfer happens on a rising edge where both are 1; while
// out_valid=1 and out_ready=0 the producer holds out_pc/out_inst unchanged.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] icache_addr;
    logic [DATA_WIDTH-1:0] icache_data;
    logic                  icache_hit;
    logic                  icache_fence_i;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  fence_i_req;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_inst;
    logic [31:0]           perf_miss_cycles;
    logic                  state_dbg;  // 1 while in the FLUSH state

    modport master (
        output icache_addr, icache_fence_i, out_valid, out_pc, out_inst,
               perf_miss_cycles, state_dbg,
        input  icache_data, icache_hit, redirect_valid, redirect_pc,
               fence_i_req, out_ready
    );

    modport slave (
        input  icache_addr, icache_fence_i, out_valid, out_pc, out_inst,
               perf_miss_cycles, state_dbg,
        output icache_data, icache_hit, redirect_valid, redirect_pc,
               fence_i_req, out_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch control: owns the PC, captures icache hits into a single-entry
// output register for decode, and handles redirects, fence.i flushes and miss counting.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h3000_0000)
) (
    input logic          clock,
    input logic          rst_n_sync,
    ifu_fetch_if.master  bus
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  fence_pulse;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_pc_q;
    logic [DATA_WIDTH-1:0] out_inst_q;
    logic [31:0]           miss_cnt;

    logic                  accept;
    logic                  miss_event;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  unused_redirect_lsbs;

    assign accept               = !out_valid_q || bus.out_ready;
    assign miss_event           = (state == ST_FETCH) && !bus.redirect_valid && !bus.icache_hit;
    assign redirect_target      = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // State register
    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a redirect always wins; FLUSH lasts exactly one cycle.
    always_comb begin
        state_next = ST_FETCH;
        if (bus.redirect_valid) begin
            state_next = bus.fence_i_req ? ST_FLUSH : ST_FETCH;
        end else if (state == ST_FLUSH) begin
            state_next = ST_FETCH;
        end
    end

    // Moore outputs
    always_comb begin
        fence_pulse = 1'b0;
        if (state == ST_FLUSH) begin
            fence_pulse = 1'b1;
        end
    end

    // PC and output register. FLUSH captures nothing so a hit sampled during the
    // invalidate cycle can never be delivered.
    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            pc          <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
        end else if (bus.redirect_valid) begin
            pc          <= redirect_target;
            out_valid_q <= 1'b0;
        end else if (state == ST_FETCH) begin
            if (bus.icache_hit) begin
                if (accept) begin
                    out_inst_q  <= bus.icache_data;
                    out_pc_q    <= pc;
                    out_valid_q <= 1'b1;
                    pc          <= pc + ADDR_WIDTH'(4);
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Saturating miss-stall counter; survives redirects and fences.
    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            miss_cnt <= '0;
        end else if (miss_event && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign bus.icache_addr      = pc;
    assign bus.icache_fence_i   = fence_pulse;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_pc           = out_pc_q;
    assign bus.out_inst         = out_inst_q;
    assign bus.perf_miss_cycles = miss_cnt;
    assign bus.state_dbg        = (state == ST_FLUSH);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus random traffic, checked against a
// queue-based reference model of the fetch stage.
module tb_ifu_fetch;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n_sync = 1'b0;
  always #5 clock = ~clock;

  ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ifu_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RESET_PC)) dut (
    .clock      (clock),
    .rst_n_sync (rst_n_sync),
    .bus        (bus)
  );

  // Icache contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign bus.icache_data = mem_word(bus.icache_addr);

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_q[$];     // {pc, inst} of the instruction decode should see next
  logic [31:0] m_pc;
  bit          m_flush;
  logic [31:0] m_miss;
  bit          chk_en;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_flush = 1'b0;
    m_miss  = 32'd0;
  endtask

  // Effect of one rising edge, using the inputs applied for that edge. The monitor
  // has already removed any instruction decode took at this edge.
  task automatic model_step();
    if (bus.redirect_valid) begin
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      m_pc    = {bus.redirect_pc[31:2], 2'b00};
      m_flush = bus.fence_i_req;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (bus.icache_hit) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
    end
  endtask

  // Monitor: compares DUT outputs with the model between edges.
  always @(negedge clock) begin
    if (chk_en) begin
      check("icache_addr", 64'(bus.icache_addr), 64'(m_pc));
      check("icache_fence_i", 64'(bus.icache_fence_i), 64'(m_flush));
      check("state_dbg", 64'(bus.state_dbg), 64'(m_flush));
      check("perf_miss_cycles", 64'(bus.perf_miss_cycles), 64'(m_miss));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_pc", 64'(bus.out_pc), 64'(exp_q[0][63:32]));
        check("out_inst", 64'(bus.out_inst), 64'(exp_q[0][31:0]));
        if (bus.out_ready && !bus.redirect_valid) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit hit, input bit rdy, input bit rv,
                       input logic [31:0] rpc, input bit fi);
    bus.icache_hit     = hit;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.fence_i_req    = fi;
  endtask

  // Advance one edge, then apply the inputs for the following edge.
  task automatic cyc(input bit hit, input bit rdy, input bit rv,
                     input logic [31:0] rpc, input bit fi);
    @(posedge clock);
    model_step();
    #1;
    drive(hit, rdy, rv, rpc, fi);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " out_pc"}, 64'(bus.out_pc), 64'd0);
    check({tag, " out_inst"}, 64'(bus.out_inst), 64'd0);
    check({tag, " icache_fence_i"}, 64'(bus.icache_fence_i), 64'd0);
    check({tag, " icache_addr"}, 64'(bus.icache_addr), 64'(RESET_PC));
    check({tag, " perf_miss_cycles"}, 64'(bus.perf_miss_cycles), 64'd0);
  endtask

  initial begin
    bit hit, rdy, rv, fi;
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Reset state, then release between edges.
    #12;
    check_reset_outputs("reset");
    #10;
    rst_n_sync = 1'b1;
    chk_en     = 1'b1;

    // Streaming: one instruction per cycle from RESET_PC.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'd0, 0);

    // Miss for 5 cycles, then hit.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'd0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 32'd0, 0);

    // Decode back-pressure for 3 cycles.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'd0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 32'd0, 0);

    // Redirect (unaligned target) squashes a held instruction.
    cyc(1, 0, 0, 32'd0, 0);
    cyc(1, 0, 1, 32'h8000_0102, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'd0, 0);

    // Redirect squashing a held instruction while decode is ready.
    cyc(1, 1, 1, 32'h8000_0200, 0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 32'd0, 0);

    // fence.i with redirect: one-cycle invalidate, no capture while flushing.
    cyc(1, 1, 1, 32'h3000_0040, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'd0, 0);

    // fence_i_req alone is ignored.
    cyc(1, 1, 0, 32'd0, 1);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 32'd0, 0);

    // PC wraps at the top of the address space.
    cyc(1, 1, 1, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'd0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      hit = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      fi  = rv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      cyc(hit, rdy, rv, $urandom(), fi);
    end

    // Asynchronous reset in the middle of a miss.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'd0, 0);
    #2;
    chk_en     = 1'b0;
    rst_n_sync = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    #2;
    rst_n_sync = 1'b1;
    chk_en     = 1'b1;
    #1;
    check("post_reset icache_addr", 64'(bus.icache_addr), 64'(RESET_PC));
    check("post_reset perf_miss_cycles", 64'(bus.perf_miss_cycles), 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'd0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 32'd0, 0);

    @(posedge clock);
    model_step();
    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
